// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle signed MULT/DIV engine.
// The optional divide-by-zero exception is enabled by defining MULTDIV_DIVZERO_EXC_EN.
package mult_div_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  // One extra bit so the counter can hold WIDTH itself (setup cycle + WIDTH steps).
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when it did not borrow.
module div_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    diff    = {1'b0, shifted} - {2'b00, divisor_i};
    q_bit_o = ~diff[WIDTH+1];
    rem_o   = q_bit_o ? diff[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) engine for the control FSM.
// Define MULTDIV_DIVZERO_EXC_EN to short-circuit divide-by-zero and raise div_zero.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int             CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

  state_e state_q, state_d;
  op_e    op_q, op_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   acc_q, acc_d, m_q, m_d;
  logic             q_1_q, q_1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept_mult, accept_div;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   step_rem;
  logic             step_qbit;

`ifdef MULTDIV_DIVZERO_EXC_EN
  logic dz_q, dz_d;
  logic b_is_zero;
  assign b_is_zero = (b == '0);
`endif

  // Only IDLE listens to the starts; mult wins a tie.
  assign accept_mult = (state_q == S_IDLE) && start_mult;
  assign accept_div  = (state_q == S_IDLE) && !start_mult && start_div;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_mult) begin
          state_d = S_MULT;
        end else if (accept_div) begin
`ifdef MULTDIV_DIVZERO_EXC_EN
          state_d = b_is_zero ? S_DONE : S_DIV;
`else
          state_d = S_DIV;
`endif
        end
      end
      S_MULT:  if (cnt_q == LAST_STEP) state_d = S_FIX;
      S_DIV:   if (cnt_q == LAST_STEP) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
`ifdef MULTDIV_DIVZERO_EXC_EN
    div_zero = done && dz_q;
`else
    div_zero = 1'b0;
`endif
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (acc_q[WIDTH-1:0]),
    .dvd_bit_i (q_q[WIDTH-1]),
    .divisor_i (m_q[WIDTH-1:0]),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  // Datapath: cnt 0 is a setup cycle, cnt 1..WIDTH perform one step each.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    q_d   = q_q;
    acc_d = acc_q;
    m_d   = m_q;
    q_1_d = q_1_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
`ifdef MULTDIV_DIVZERO_EXC_EN
    dz_d  = dz_q;
`endif

    case ({q_q[0], q_1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase

    a_abs = a_q[WIDTH-1] ? -a_q : a_q;
    b_abs = b_q[WIDTH-1] ? -b_q : b_q;

    case (state_q)
      S_IDLE: begin
        if (accept_mult || accept_div) begin
          a_d   = a;
          b_d   = b;
          cnt_d = '0;
          op_d  = accept_div ? OP_DIV : OP_MULT;
`ifdef MULTDIV_DIVZERO_EXC_EN
          dz_d  = accept_div && b_is_zero;
`endif
        end
      end
      S_MULT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          acc_d = '0;
          q_d   = b_q;
          q_1_d = 1'b0;
          m_d   = {a_q[WIDTH-1], a_q};
        end else begin
          // Arithmetic shift right of {acc, q, q_1}; acc carries a guard bit for -2^(WIDTH-1).
          acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
          q_1_d = q_q[0];
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          acc_d = '0;
          q_d   = a_abs;
          m_d   = {1'b0, b_abs};
        end else begin
          acc_d = step_rem;
          q_d   = {q_q[WIDTH-2:0], step_qbit};
        end
      end
      S_FIX: begin
        if (op_q == OP_MULT) begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = q_q;
        end else begin
          // Truncating division: remainder follows the dividend's sign.
          lo_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -q_q : q_q;
          hi_d = a_q[WIDTH-1] ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_MULT;
      q_q   <= '0;
      acc_q <= '0;
      m_q   <= '0;
      q_1_q <= 1'b0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
`ifdef MULTDIV_DIVZERO_EXC_EN
      dz_q  <= 1'b0;
`endif
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      q_q   <= q_d;
      acc_q <= acc_d;
      m_q   <= m_d;
      q_1_q <= q_1_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
`ifdef MULTDIV_DIVZERO_EXC_EN
      dz_q  <= dz_d;
`endif
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: arithmetic results, latency, control flow and reset abort.
// Expectations for divide-by-zero follow MULTDIV_DIVZERO_EXC_EN.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_mult, start_div;
  logic [W-1:0]  a, b, hi, lo;
  logic          busy, done, div_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Presents a one-cycle start; returns 1ns after the accepting edge.
  task automatic launch(input logic sm, input logic sd, input logic [W-1:0] ta, input logic [W-1:0] tb);
    @(negedge clk);
    start_mult = sm;
    start_div  = sd;
    a          = ta;
    b          = tb;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = $urandom;
    b          = $urandom;
  endtask

  // Counts edges until done is seen; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic op_check(input string tag, input logic sm, input logic sd,
                          input logic [W-1:0] ta, input logic [W-1:0] tb, input int exp_lat,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dz);
    int lat;
    launch(sm, sd, ta, tb);
    check({tag, "_busy"}, 64'(busy), 64'(1));
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int lat;
    int seen;

    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = '0;
    b          = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // 7 * -3 = -21
    op_check("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    // Max positive squared; hi/lo must hold the old result while busy.
    launch(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    repeat (10) @(posedge clk);
    #1;
    check("hold_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("hold_lo", 64'(lo), 64'(32'hFFFF_FFEB));
    wait_done(lat);
    check("mul_max_lat", 64'(lat + 10), 64'(LAT));
    check("mul_max_hi", 64'(hi), 64'(32'h3FFF_FFFF));
    check("mul_max_lo", 64'(lo), 64'(32'h0000_0001));
    @(posedge clk);
    #1;

    // -7 / 2 = -3 rem -1
    op_check("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    // Most negative / -1 wraps
    op_check("div_wrap", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, LAT, 32'h0000_0000, 32'h8000_0000, 1'b0);
    // Both starts: product 15, not quotient 0 rem 3
    op_check("both", 1'b1, 1'b1, 32'd3, 32'd5, LAT, 32'h0000_0000, 32'h0000_000F, 1'b0);

    // start_div during busy is ignored: result stays -2 * 6 = -12
    launch(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd6);
    repeat (10) @(posedge clk);
    @(negedge clk);
    start_div = 1'b1;
    a         = 32'd100;
    b         = 32'd7;
    @(posedge clk);
    #1;
    start_div = 1'b0;
    wait_done(lat);
    check("ign_lat", 64'(lat + 11), 64'(LAT));
    check("ign_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("ign_lo", 64'(lo), 64'(32'hFFFF_FFF4));
    repeat (3) @(posedge clk);
    #1;
    check("ign_not_queued", 64'(busy), 64'(0));

`ifdef MULTDIV_DIVZERO_EXC_EN
    op_check("div_zero", 1'b0, 1'b1, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b1);
`else
    op_check("div_zero", 1'b0, 1'b1, 32'd5, 32'd0, LAT, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0);
`endif

    // Reset 15 cycles into a mult aborts it.
    launch(1'b1, 1'b0, 32'd3, 32'd3);
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'(0));

    // Recovery after abort: 100 / 7 = 14 rem 2
    op_check("div_100_7", 1'b0, 1'b1, 32'd100, 32'd7, LAT, 32'h0000_0002, 32'h0000_000E, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
